// File: rtl/norm_grs_pkg.sv
// norm_grs_pkg: shared definitions for the FP adder post-add normalizer.
//   - default field widths for the significand fraction and biased exponent
//   - FSM state encoding used by norm_grs
//   - EXP_MAX (all-ones exponent) for the default exponent width
//   - bit-index constants for G/R/S and helpers for the carry/hidden positions
package norm_grs_pkg;

    localparam int SIG_WD_DEF = 23;
    localparam int EXP_WD_DEF = 8;

    localparam logic [EXP_WD_DEF-1:0] EXP_MAX = '1;

    // Positions inside the raw sum vector {carry, hidden, fraction, G, R, S}
    localparam int IDX_S = 0;
    localparam int IDX_R = 1;
    localparam int IDX_G = 2;

    function automatic int idx_hidden(input int sig_wd);
        return sig_wd + 3;
    endfunction

    function automatic int idx_carry(input int sig_wd);
        return sig_wd + 4;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RSHIFT = 2'd1,
        LSHIFT = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/norm_grs_shift_step.sv
// norm_shift_step: combinational single-bit normalization step.
//   i_vec   : {carry, hidden, fraction, G, R, S} working vector
//   i_exp   : current biased exponent
//   i_right : 1 = shift right by one (exponent +1), 0 = shift left by one (exponent -1)
//   o_vec   : shifted vector; on a right shift the bit dropped off the LSB is ORed into S
//   o_exp   : adjusted exponent, one bit wider than i_exp so overflow is visible
module norm_shift_step
    import norm_grs_pkg::*;
#(
    parameter int Significant_WD = SIG_WD_DEF,
    parameter int Exponent_WD    = EXP_WD_DEF
) (
    input  logic [Significant_WD+4:0] i_vec,
    input  logic [Exponent_WD-1:0]    i_exp,
    input  logic                      i_right,
    output logic [Significant_WD+4:0] o_vec,
    output logic [Exponent_WD:0]      o_exp
);

    localparam int VW = Significant_WD + 5;
    localparam int XW = Exponent_WD + 1;
    localparam logic [XW-1:0] ONE = XW'(1);

    logic [XW-1:0] w_exp_wide;

    assign w_exp_wide = {1'b0, i_exp};

    always_comb begin
        o_vec = i_vec;
        o_exp = w_exp_wide;
        if (i_right) begin
            // New S keeps the old R and the old S that falls off the end
            o_vec = {1'b0, i_vec[VW-1:IDX_R+1], i_vec[IDX_R] | i_vec[IDX_S]};
            o_exp = w_exp_wide + ONE;
        end else begin
            o_vec = {i_vec[VW-2:0], 1'b0};
            o_exp = w_exp_wide - ONE;
        end
    end

endmodule

// File: rtl/norm_grs.sv
// norm_grs: multi-cycle post-add normalizer between the significand adder
// and the rounder.
//   CLK, RST         : clock (rising edge), asynchronous active-low reset
//   In_Valid/In_Ready: upstream handshake for Sum_in/Exp_in/Sign_in
//   Sum_in           : {carry, hidden, fraction, G, R, S} raw adder sum
//   Exp_in, Sign_in  : biased exponent and sign of the sum
//   Out_Valid/Out_Ready: downstream handshake to the rounder
//   Min              : normalized {hidden, fraction, G, R, S}
//   Exp_out, Sign_out: adjusted exponent, registered sign
//   zero_flag        : sum was exactly zero
//   ovf_flag         : carry shift pushed the exponent to all-ones
//   unf_flag         : left shift stopped at the minimum exponent (denormal)
module norm_grs
    import norm_grs_pkg::*;
#(
    parameter int Significant_WD = SIG_WD_DEF,
    parameter int Exponent_WD    = EXP_WD_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      In_Valid,
    output logic                      In_Ready,
    input  logic [Significant_WD+4:0] Sum_in,
    input  logic [Exponent_WD-1:0]    Exp_in,
    input  logic                      Sign_in,
    output logic                      Out_Valid,
    input  logic                      Out_Ready,
    output logic [Significant_WD+3:0] Min,
    output logic [Exponent_WD-1:0]    Exp_out,
    output logic                      Sign_out,
    output logic                      zero_flag,
    output logic                      ovf_flag,
    output logic                      unf_flag
);

    localparam int VW = Significant_WD + 5;
    localparam int XW = Exponent_WD + 1;
    localparam int CI = idx_carry(Significant_WD);
    localparam int HI = idx_hidden(Significant_WD);
    localparam logic [XW-1:0]          EXP_ALL1_W = {1'b0, {Exponent_WD{1'b1}}};
    localparam logic [XW-1:0]          EXP_ONE_W  = XW'(1);
    localparam logic [Exponent_WD-1:0] EXP_ONE    = Exponent_WD'(1);

    state_t                  r_state, w_state_nxt;
    logic [VW-1:0]           r_vec,   w_vec_nxt;
    logic [Exponent_WD-1:0]  r_exp,   w_exp_nxt;
    logic                    r_sign,  w_sign_nxt;
    logic                    r_zero,  w_zero_nxt;
    logic                    r_ovf,   w_ovf_nxt;
    logic                    r_unf,   w_unf_nxt;
    logic                    r_valid, w_valid_nxt;

    logic [VW-1:0]           w_step_vec;
    logic [XW-1:0]           w_step_exp;

    norm_shift_step #(
        .Significant_WD (Significant_WD),
        .Exponent_WD    (Exponent_WD)
    ) u_step (
        .i_vec   (r_vec),
        .i_exp   (r_exp),
        .i_right (r_state == RSHIFT),
        .o_vec   (w_step_vec),
        .o_exp   (w_step_exp)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_vec   <= '0;
            r_exp   <= '0;
            r_sign  <= 1'b0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_vec   <= w_vec_nxt;
            r_exp   <= w_exp_nxt;
            r_sign  <= w_sign_nxt;
            r_zero  <= w_zero_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vec_nxt   = r_vec;
        w_exp_nxt   = r_exp;
        w_sign_nxt  = r_sign;
        w_zero_nxt  = r_zero;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_valid_nxt = r_valid;

        case (r_state)
            IDLE: begin
                if (In_Valid) begin
                    w_vec_nxt  = Sum_in;
                    w_exp_nxt  = Exp_in;
                    w_sign_nxt = Sign_in;
                    w_zero_nxt = 1'b0;
                    w_ovf_nxt  = 1'b0;
                    w_unf_nxt  = 1'b0;
                    if (Sum_in == '0) begin
                        w_exp_nxt   = '0;
                        w_zero_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end else if (Sum_in[CI]) begin
                        w_state_nxt = RSHIFT;
                    end else if (Sum_in[HI]) begin
                        // Two denormals carried into the hidden bit: smallest normal exponent
                        if (Exp_in == '0) begin
                            w_exp_nxt = EXP_ONE;
                        end
                        w_state_nxt = DONE;
                    end else if (Exp_in == '0) begin
                        w_unf_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = LSHIFT;
                    end
                end
            end

            RSHIFT: begin
                w_vec_nxt = w_step_vec;
                if (w_step_exp >= EXP_ALL1_W) begin
                    w_exp_nxt = '1;
                    w_ovf_nxt = 1'b1;
                end else begin
                    w_exp_nxt = w_step_exp[Exponent_WD-1:0];
                end
                w_state_nxt = DONE;
            end

            LSHIFT: begin
                // Exponent already at the floor (Exp_in==1): no shift possible
                if (r_exp <= EXP_ONE) begin
                    w_exp_nxt   = '0;
                    w_unf_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_vec_nxt = w_step_vec;
                    w_exp_nxt = w_step_exp[Exponent_WD-1:0];
                    if (w_step_vec[HI]) begin
                        w_state_nxt = DONE;
                    end else if (w_step_exp == EXP_ONE_W) begin
                        w_exp_nxt   = '0;
                        w_unf_nxt   = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end

            DONE: begin
                // Out_Valid rises one cycle after entering DONE
                if (r_valid && Out_Ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end else begin
                    w_valid_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign In_Ready  = (r_state == IDLE);
    assign Out_Valid = r_valid;
    assign Min       = r_vec[HI:0];
    assign Exp_out   = r_exp;
    assign Sign_out  = r_sign;
    assign zero_flag = r_zero;
    assign ovf_flag  = r_ovf;
    assign unf_flag  = r_unf;

endmodule

// File: tb/tb_norm_grs.sv
module tb_norm_grs;

    localparam int SW = 23;
    localparam int EW = 8;

    logic          CLK;
    logic          RST;
    logic          In_Valid;
    logic          In_Ready;
    logic [SW+4:0] Sum_in;
    logic [EW-1:0] Exp_in;
    logic          Sign_in;
    logic          Out_Valid;
    logic          Out_Ready;
    logic [SW+3:0] Min;
    logic [EW-1:0] Exp_out;
    logic          Sign_out;
    logic          zero_flag;
    logic          ovf_flag;
    logic          unf_flag;

    int n_vec = 0;
    int n_err = 0;

    norm_grs #(
        .Significant_WD (SW),
        .Exponent_WD    (EW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Sum_in    (Sum_in),
        .Exp_in    (Exp_in),
        .Sign_in   (Sign_in),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Min       (Min),
        .Exp_out   (Exp_out),
        .Sign_out  (Sign_out),
        .zero_flag (zero_flag),
        .ovf_flag  (ovf_flag),
        .unf_flag  (unf_flag)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one sum, then count cycles from the accept edge until Out_Valid.
    task automatic run_vec(input string tag, input logic [SW+4:0] sum, input logic [EW-1:0] e,
                           input logic sg, input int lat_exp, input logic [SW+3:0] min_exp,
                           input logic [EW-1:0] eo_exp, input logic z, input logic o, input logic u);
        int lat;
        for (int i = 0; i < 50 && !In_Ready; i++) begin
            @(posedge CLK); #1;
        end
        Sum_in   = sum;
        Exp_in   = e;
        Sign_in  = sg;
        In_Valid = 1'b1;
        @(posedge CLK); #1;
        In_Valid = 1'b0;
        Sum_in   = '0;
        Exp_in   = '0;
        lat = 0;
        while (!Out_Valid && lat < 64) begin
            @(posedge CLK); #1;
            lat++;
        end
        chk({tag, ".latency"}, 64'(lat), 64'(lat_exp));
        chk({tag, ".Min"},     64'(Min), 64'(min_exp));
        chk({tag, ".Exp_out"}, 64'(Exp_out), 64'(eo_exp));
        chk({tag, ".Sign_out"}, 64'(Sign_out), 64'(sg));
        chk({tag, ".zero"},    64'(zero_flag), 64'(z));
        chk({tag, ".ovf"},     64'(ovf_flag), 64'(o));
        chk({tag, ".unf"},     64'(unf_flag), 64'(u));
        chk({tag, ".In_Ready_busy"}, 64'(In_Ready), 64'(0));
    endtask

    task automatic release_out(input string tag);
        Out_Ready = 1'b1;
        @(posedge CLK); #1;
        Out_Ready = 1'b0;
        chk({tag, ".Out_Valid_drop"}, 64'(Out_Valid), 64'(0));
        chk({tag, ".In_Ready_back"},  64'(In_Ready), 64'(1));
    endtask

    initial begin
        RST       = 1'b0;
        In_Valid  = 1'b0;
        Sum_in    = '0;
        Exp_in    = '0;
        Sign_in   = 1'b0;
        Out_Ready = 1'b0;
        #2;
        chk("rst.Out_Valid", 64'(Out_Valid), 64'(0));
        chk("rst.In_Ready",  64'(In_Ready), 64'(1));
        chk("rst.Min",       64'(Min), 64'(0));
        chk("rst.Exp_out",   64'(Exp_out), 64'(0));
        chk("rst.flags",     64'({Sign_out, zero_flag, ovf_flag, unf_flag}), 64'(0));
        #10;
        RST = 1'b1;

        // Already normalized: no shift
        run_vec("norm", 28'h4000001, 8'd127, 1'b0, 1, 27'h4000001, 8'd127, 0, 0, 0);
        release_out("norm");

        // Carry: right shift, dropped S folded into new S
        run_vec("carry", 28'h8000003, 8'd127, 1'b1, 2, 27'h4000001, 8'd128, 0, 0, 0);
        release_out("carry");

        // Three left shifts
        run_vec("lsh3", 28'h0800000, 8'd127, 1'b0, 4, 27'h4000000, 8'd124, 0, 0, 0);
        release_out("lsh3");

        // Exact zero
        run_vec("zero", 28'h0000000, 8'd100, 1'b1, 1, 27'h0000000, 8'd0, 1, 0, 0);
        release_out("zero");

        // Left shift stops at exponent 1 after two shifts
        run_vec("unf", 28'h0010000, 8'd3, 1'b0, 3, 27'h0040000, 8'd0, 0, 0, 1);
        release_out("unf");

        // Denormal input with nothing to shift
        run_vec("den0", 28'h0000010, 8'd0, 1'b0, 1, 27'h0000010, 8'd0, 0, 0, 1);
        release_out("den0");

        // Denormal carried into hidden bit: exponent becomes 1
        run_vec("den1", 28'h4000000, 8'd0, 1'b1, 1, 27'h4000000, 8'd1, 0, 0, 0);
        release_out("den1");

        // Overflow with backpressure; a stray In_Valid must be ignored while busy
        run_vec("ovf", 28'h8000000, 8'd254, 1'b0, 2, 27'h4000000, 8'd255, 0, 1, 0);
        Sum_in   = 28'h0800000;
        Exp_in   = 8'd10;
        In_Valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("bp.Out_Valid", 64'(Out_Valid), 64'(1));
            chk("bp.In_Ready",  64'(In_Ready), 64'(0));
            chk("bp.Min",       64'(Min), 64'h4000000);
            chk("bp.Exp_out",   64'(Exp_out), 64'd255);
            chk("bp.ovf",       64'(ovf_flag), 64'(1));
        end
        In_Valid = 1'b0;
        release_out("ovf");

        // Flags cleared on the next accept
        run_vec("clr", 28'h4000004, 8'd20, 1'b0, 1, 27'h4000004, 8'd20, 0, 0, 0);
        release_out("clr");

        // Reset in the middle of a 10-bit left shift
        Sum_in   = 28'h0010000;
        Exp_in   = 8'd127;
        In_Valid = 1'b1;
        @(posedge CLK); #1;
        In_Valid = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("mrst.Out_Valid", 64'(Out_Valid), 64'(0));
        chk("mrst.In_Ready",  64'(In_Ready), 64'(1));
        chk("mrst.Min",       64'(Min), 64'(0));
        @(negedge CLK);
        RST = 1'b1;

        run_vec("post", 28'h1000000, 8'd50, 1'b1, 3, 27'h4000000, 8'd48, 0, 0, 0);
        release_out("post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/norm_grs.md
Name: norm_grs

Overview:
- Multi-cycle post-add normalizer for the FP adder datapath; sits between the significand adder/subtractor and the rounding stage.
- Takes the raw adder sum (carry, hidden, fraction, G/R/S) and its exponent.
- Normalizes by a 1-bit right shift or iterative left shifts, folding shifted-out bits into sticky.
- Delivers the {hidden, fraction, G, R, S} vector the rounder consumes, with a valid/ready handshake on both sides.

Parameters:
Significant_WD, 23, fraction width excluding hidden bit
Exponent_WD, 8, biased exponent width

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  reset, asynchronous, active-low
In_Valid  input  1  upstream sum/exponent valid
In_Ready  output  1  block can accept a new sum
Sum_in  input  Significant_WD+5  [MSB]=carry, [MSB-1]=hidden, [Significant_WD+2:3]=fraction, [2:0]=G,R,S
Exp_in  input  Exponent_WD  biased exponent of the sum
Sign_in  input  1  sign of the result
Out_Valid  output  1  normalized result valid
Out_Ready  input  1  rounder accepts the result
Min  output  Significant_WD+4  {hidden, fraction, G, R, S} to the rounder
Exp_out  output  Exponent_WD  adjusted exponent
Sign_out  output  1  registered Sign_in
zero_flag  output  1  sum was exactly zero
ovf_flag  output  1  exponent reached all-ones after carry shift
unf_flag  output  1  left shift stopped at minimum exponent (denormal result)

Behaviour:
- Reset (RST low, asynchronous): state IDLE; Out_Valid=0, In_Ready=1, Min=0, Exp_out=0, Sign_out=0, all flags 0. Reset mid-operation discards any in-flight sum.
- FSM states: IDLE, RSHIFT, LSHIFT, DONE. Internal exponent arithmetic uses Exponent_WD+1 bits.
- IDLE: In_Ready=1. On In_Valid, capture Sum_in, Exp_in and Sign_in, then branch:
  - Sum_in==0: Min=0, Exp_out=0, zero_flag=1 -> DONE.
  - carry=1 -> RSHIFT.
  - hidden=1 -> DONE.
  - Exp_in==0 and hidden=0: denormal with nothing to shift; Exp_out=0, unf_flag=1 -> DONE.
  - Otherwise -> LSHIFT.
- RSHIFT (1 cycle):
  - Vector shifts right by 1; new S = old S OR bit shifted out; exponent +1.
  - If the result exponent is all-ones, set ovf_flag=1 and keep the shifted Min.
  - -> DONE.
- LSHIFT (1 bit per cycle):
  - Vector shifts left by 1 with 0 inserted at the LSB; exponent -1.
  - hidden becomes 1 -> DONE.
  - Exponent reaches 1 with hidden still 0: Exp_out=0, unf_flag=1, stop shifting -> DONE.
  - Maximum Significant_WD+3 iterations.
- DONE: Out_Valid=1; Min/Exp_out/Sign_out/flags held stable. In_Ready=0. Out_Ready=1 -> IDLE, Out_Valid=0 the next cycle.
- No new input is accepted while busy. Back-to-back operation: at most one result per (latency+1) cycles.
- Latency is counted from the accept edge k:
  - Normalized or zero input: Out_Valid high after edge k+1.
  - Carry input: after edge k+2.
  - n-bit left shift: after edge k+1+n.
- Flags are cleared on every accept.
- A sum with Exp_in==0 and hidden=1 (denormal+denormal carried into normal) is output with Exp_out=1.

Decomposition:
- Shared FP package holds: field widths (Significant_WD, Exponent_WD), FSM state encoding, EXP_MAX (all-ones) constant, bit-index constants for carry/hidden/G/R/S.
- One natural sub-module, norm_shift_step: combinational 1-bit left/right shift with sticky folding and exponent increment/decrement, instantiated once and driven by the FSM.

Test Plan:
- Normalized: Sum_in=28'h4000001, Exp_in=127 -> Min=27'h4000001, Exp_out=127, no flags, Out_Valid after edge k+1.
- Carry: Sum_in=28'h8000003, Exp_in=127 -> Min=27'h4000001 (S=1 from lost bit), Exp_out=128, Out_Valid after edge k+2.
- Left shift 3: Sum_in=28'h0800000, Exp_in=127 -> Min=27'h4000000, Exp_out=124, Out_Valid after edge k+4.
- Zero and underflow:
  - Sum_in=0, Exp_in=100 -> Min=0, Exp_out=0, zero_flag=1.
  - Sum_in=28'h0010000, Exp_in=3 -> Min=27'h0040000, Exp_out=0, unf_flag=1 after 2 shifts.
- Overflow plus backpressure: Sum_in=28'h8000000, Exp_in=254 -> Exp_out=255, ovf_flag=1.
  - Out_Ready low 3 cycles: outputs stable, In_Ready=0.
  - Out_Ready high: IDLE next cycle.
- Reset mid-LSHIFT: assert RST low during a 10-bit shift -> Out_Valid=0, In_Ready=1 immediately; the next accepted sum is processed correctly.
